// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle RV32 controller.
// Holds the FSM state enum, supported opcodes, ALU operation codes,
// datapath mux-select encodings and small decode helpers.
// Optional feature macro: MC_SHIFT_EN (enables sll / slli decode).
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_RTYPE  = 7'h33;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_BRANCH = 7'h63;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_ALUOUT = 1'b1;

  // Immediate format used while DECODE precomputes the branch target.
  function automatic logic [1:0] imm_src_for(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      default:   return IMM_I;
    endcase
  endfunction

  // Opcodes that leave DECODE for a real execution path.
  function automatic logic opcode_supported(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH: return 1'b1;
`ifdef MC_SHIFT_EN
      OP_IMM: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: control/status bundle between the multicycle
// controller and the datapath.
//   master modport: the controller (reads instruction fields and status,
//                   drives mux selects and write enables)
//   slave  modport: the datapath side (the reverse directions)
interface multicycle_controller_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       ir_write;
  logic       adr_src;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] alu_op;
  logic [1:0] imm_src;
  logic [1:0] result_src;
  logic       illegal;

  modport master (
    input  opcode, funct3, funct7b5, zero, mem_ready,
    output pc_write, ir_write, adr_src, mem_write, reg_write,
           alu_src_a, alu_src_b, alu_op, imm_src, result_src, illegal
  );

  modport slave (
    output opcode, funct3, funct7b5, zero, mem_ready,
    input  pc_write, ir_write, adr_src, mem_write, reg_write,
           alu_src_a, alu_src_b, alu_op, imm_src, result_src, illegal
  );
endinterface

// File: rtl/mc_alu_decoder.sv
// mc_alu_decoder: combinational R-type ALU decode.
//   funct3, funct7b5 in  -> alu_op (4 bits), legal (1 = supported funct3)
// Unsupported encodings report legal=0 and leave alu_op at add.
// Optional feature macro: MC_SHIFT_EN (funct3 001 decodes as sll).
module mc_alu_decoder
  import mc_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] alu_op,
  output logic       legal
);

  always_comb begin
    alu_op = ALU_ADD;
    legal  = 1'b1;
    case (funct3)
      3'b000: alu_op = funct7b5 ? ALU_SUB : ALU_ADD;
      3'b111: alu_op = ALU_AND;
      3'b110: alu_op = ALU_OR;
      3'b010: alu_op = ALU_SLT;
`ifdef MC_SHIFT_EN
      3'b001: alu_op = ALU_SLL;
`endif
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: sequencing FSM for the shared-memory multicycle
// RV32 datapath (FETCH/DECODE/MEMADR/MEMREAD/MEMWB/MEMWRITE/EXECR/EXECI/
// ALUWB/BEQ). All state changes on the falling edge of clock to line up
// with the datapath registers.
//   clock   in   system clock (falling-edge active)
//   clear   in   synchronous active-high reset
//   bus     master modport of multicycle_controller_if (decode inputs,
//                zero, mem_ready; all selects and write enables)
//   retired out  count of completed instructions, wraps modulo 2^CNT_W
// Optional feature macro: MC_SHIFT_EN (sll / slli support).
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                    clock,
  input  logic                    clear,
  multicycle_controller_if.master bus,
  output logic [CNT_W-1:0]        retired
);

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] retired_reg;
  logic [3:0]       dec_alu_op;
  logic             dec_legal;
  logic             retire_now;

  mc_alu_decoder u_alu_dec (
    .funct3   (bus.funct3),
    .funct7b5 (bus.funct7b5),
    .alu_op   (dec_alu_op),
    .legal    (dec_legal)
  );

  always_ff @(negedge clock) begin
    if (clear) state_reg <= FETCH;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FETCH:    if (bus.mem_ready) state_next = DECODE;
      DECODE: begin
        case (bus.opcode)
          OP_LOAD, OP_STORE: state_next = MEMADR;
          OP_RTYPE:          state_next = EXECR;
`ifdef MC_SHIFT_EN
          OP_IMM:            state_next = EXECI;
`endif
          OP_BRANCH:         state_next = BEQ;
          default:           state_next = FETCH;
        endcase
      end
      MEMADR:   state_next = (bus.opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (bus.mem_ready) state_next = MEMWB;
      MEMWRITE: if (bus.mem_ready) state_next = FETCH;
      EXECR:    state_next = dec_legal ? ALUWB : FETCH;
      EXECI:    state_next = (bus.funct3 == 3'b001) ? ALUWB : FETCH;
      MEMWB, ALUWB, BEQ: state_next = FETCH;
      default:  state_next = FETCH;
    endcase
  end

  // Only completing states count; an illegal bail-out to FETCH does not.
  always_comb begin
    retire_now = 1'b0;
    if (state_next == FETCH) begin
      case (state_reg)
        MEMWB, MEMWRITE, ALUWB, BEQ: retire_now = 1'b1;
        default:                     retire_now = 1'b0;
      endcase
    end
  end

  always_ff @(negedge clock) begin
    if (clear)           retired_reg <= '0;
    else if (retire_now) retired_reg <= retired_reg + CNT_W'(1);
  end

  assign retired = retired_reg;

  always_comb begin
    bus.pc_write   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.adr_src    = ADR_PC;
    bus.mem_write  = 1'b0;
    bus.reg_write  = 1'b0;
    bus.alu_src_a  = SRCA_PC;
    bus.alu_src_b  = SRCB_REG;
    bus.alu_op     = ALU_ADD;
    bus.imm_src    = IMM_I;
    bus.result_src = RES_ALUOUT;
    bus.illegal    = 1'b0;
    case (state_reg)
      FETCH: begin
        // PC+4 goes straight from the ALU into PC once the fetch lands.
        bus.alu_src_b  = SRCB_FOUR;
        bus.result_src = RES_ALU;
        bus.pc_write   = bus.mem_ready;
        bus.ir_write   = bus.mem_ready;
      end
      DECODE: begin
        bus.alu_src_a = SRCA_OLDPC;
        bus.alu_src_b = SRCB_IMM;
        bus.imm_src   = imm_src_for(bus.opcode);
        bus.illegal   = !opcode_supported(bus.opcode);
      end
      MEMADR: begin
        bus.alu_src_a = SRCA_REG;
        bus.alu_src_b = SRCB_IMM;
      end
      MEMREAD:  bus.adr_src = ADR_ALUOUT;
      MEMWB: begin
        bus.result_src = RES_DATA;
        bus.reg_write  = 1'b1;
      end
      MEMWRITE: begin
        bus.adr_src   = ADR_ALUOUT;
        bus.mem_write = 1'b1;
      end
      EXECR: begin
        bus.alu_src_a = SRCA_REG;
        bus.alu_op    = dec_alu_op;
        bus.illegal   = !dec_legal;
      end
`ifdef MC_SHIFT_EN
      EXECI: begin
        bus.alu_src_a = SRCA_REG;
        bus.alu_src_b = SRCB_IMM;
        if (bus.funct3 == 3'b001) bus.alu_op = ALU_SLL;
        else                      bus.illegal = 1'b1;
      end
`endif
      ALUWB:    bus.reg_write = 1'b1;
      BEQ: begin
        bus.alu_src_a = SRCA_REG;
        bus.alu_op    = ALU_SUB;
        bus.pc_write  = bus.zero;
      end
      default: ;
    endcase
    // Reset must never let a write escape, whatever state we are in.
    if (clear) begin
      bus.pc_write  = 1'b0;
      bus.ir_write  = 1'b0;
      bus.mem_write = 1'b0;
      bus.reg_write = 1'b0;
      bus.illegal   = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: scoreboard bench for multicycle_controller.
// The stimulus process walks each instruction through the behaviour the
// controller should show, pushing one expected control vector per cycle;
// a monitor pops and compares on every rising edge (mid-cycle for the
// falling-edge FSM). A narrow counter exercises retired wrap-around.
module tb_multicycle_controller;
  localparam int CNT_W = 6;

  typedef struct {
    string            name;
    logic             pc_write, ir_write, adr_src, mem_write, reg_write;
    logic [1:0]       src_a, src_b;
    logic [3:0]       alu_op;
    logic [1:0]       imm_src, result_src;
    logic             illegal;
    logic [CNT_W-1:0] retired;
  } exp_t;

  logic             clock = 1'b0;
  logic             clear;
  logic [CNT_W-1:0] retired;
  logic [6:0]       cur_op;
  logic [2:0]       cur_f3;
  logic             cur_f7;
  int               ret_model;
  int               checks = 0;
  int               fails  = 0;
  int               cycle  = 0;
  exp_t             exp_q[$];
  bit               shift_en;

  multicycle_controller_if bus();

  multicycle_controller #(.CNT_W(CNT_W)) dut (
    .clock   (clock),
    .clear   (clear),
    .bus     (bus),
    .retired (retired)
  );

  always #5 clock = ~clock;

  function automatic logic [18+CNT_W-1:0] pack(input exp_t e);
    return {e.pc_write, e.ir_write, e.adr_src, e.mem_write, e.reg_write,
            e.src_a, e.src_b, e.alu_op, e.imm_src, e.result_src,
            e.illegal, e.retired};
  endfunction

  function automatic exp_t base(input string nm);
    exp_t e;
    e.name = nm;
    e.pc_write = 0; e.ir_write = 0; e.adr_src = 0; e.mem_write = 0;
    e.reg_write = 0; e.src_a = 2'b00; e.src_b = 2'b00; e.alu_op = 4'b0010;
    e.imm_src = 2'b00; e.result_src = 2'b00; e.illegal = 0;
    e.retired = CNT_W'(ret_model % (1 << CNT_W));
    return e;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // One controller cycle: inputs applied just after the falling edge.
  task automatic cyc(input logic rdy, input logic clr, input logic zr, input exp_t e);
    @(negedge clock);
    #1;
    clear         = clr;
    bus.mem_ready = rdy;
    bus.zero      = zr;
    bus.opcode    = cur_op;
    bus.funct3    = cur_f3;
    bus.funct7b5  = cur_f7;
    exp_q.push_back(e);
  endtask

  task automatic retire_one();
    ret_model = (ret_model + 1) % (1 << CNT_W);
  endtask

  // Expected behaviour of one instruction; clr_mem asserts clear in the
  // first memory-access cycle of a store.
  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                           input logic zr, input bit clr_mem);
    exp_t e;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       legal;
    logic [3:0] aop;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[30];
    $display("instr %08h op=%02h f3=%0d fetch_wait=%0d mem_wait=%0d zero=%0b clear_in_mem=%0b",
             ins, op, f3, fw, mw, zr, clr_mem);
    cur_op = op; cur_f3 = f3; cur_f7 = f7;
    // fetch: PC+4 through the ALU, writes only when memory answers
    for (int i = 0; i < fw; i++) begin
      e = base("fetch_wait"); e.src_b = 2'b10; e.result_src = 2'b10;
      cyc(1'b0, 1'b0, rb(), e);
    end
    e = base("fetch"); e.src_b = 2'b10; e.result_src = 2'b10;
    e.pc_write = 1; e.ir_write = 1;
    cyc(1'b1, 1'b0, rb(), e);
    // decode: branch target precompute
    e = base("decode"); e.src_a = 2'b01; e.src_b = 2'b01;
    e.imm_src = (op == 7'h23) ? 2'b01 : (op == 7'h63) ? 2'b10 : 2'b00;
    legal = (op == 7'h03) || (op == 7'h23) || (op == 7'h33) || (op == 7'h63) ||
            ((op == 7'h13) && shift_en);
    e.illegal = !legal;
    cyc(rb(), 1'b0, rb(), e);
    if (!legal) return;
    if (op == 7'h03 || op == 7'h23) begin
      e = base("memadr"); e.src_a = 2'b10; e.src_b = 2'b01;
      cyc(rb(), 1'b0, rb(), e);
      if (op == 7'h03) begin
        for (int i = 0; i < mw; i++) begin
          e = base("memread_wait"); e.adr_src = 1;
          cyc(1'b0, 1'b0, rb(), e);
        end
        e = base("memread"); e.adr_src = 1;
        cyc(1'b1, 1'b0, rb(), e);
        e = base("memwb"); e.result_src = 2'b01; e.reg_write = 1;
        cyc(rb(), 1'b0, rb(), e);
        retire_one();
      end else if (clr_mem) begin
        e = base("memwrite_clear"); e.adr_src = 1;
        cyc(rb(), 1'b1, rb(), e);
        ret_model = 0;
        cur_op = 7'h00;
      end else begin
        for (int i = 0; i < mw; i++) begin
          e = base("memwrite_wait"); e.adr_src = 1; e.mem_write = 1;
          cyc(1'b0, 1'b0, rb(), e);
        end
        e = base("memwrite"); e.adr_src = 1; e.mem_write = 1;
        cyc(1'b1, 1'b0, rb(), e);
        retire_one();
      end
    end else if (op == 7'h33) begin
      legal = 1'b1;
      case (f3)
        3'b000:  aop = f7 ? 4'b0110 : 4'b0010;
        3'b111:  aop = 4'b0000;
        3'b110:  aop = 4'b0001;
        3'b010:  aop = 4'b0111;
        3'b001:  begin aop = shift_en ? 4'b1000 : 4'b0010; legal = shift_en; end
        default: begin aop = 4'b0010; legal = 1'b0; end
      endcase
      e = base("execr"); e.src_a = 2'b10; e.src_b = 2'b00; e.alu_op = aop;
      e.illegal = !legal;
      cyc(rb(), 1'b0, rb(), e);
      if (legal) begin
        e = base("aluwb"); e.reg_write = 1;
        cyc(rb(), 1'b0, rb(), e);
        retire_one();
      end
    end else if (op == 7'h13) begin
      e = base("execi"); e.src_a = 2'b10; e.src_b = 2'b01;
      e.alu_op = (f3 == 3'b001) ? 4'b1000 : 4'b0010;
      e.illegal = (f3 != 3'b001);
      cyc(rb(), 1'b0, rb(), e);
      if (f3 == 3'b001) begin
        e = base("aluwb"); e.reg_write = 1;
        cyc(rb(), 1'b0, rb(), e);
        retire_one();
      end
    end else begin
      e = base("beq"); e.src_a = 2'b10; e.alu_op = 4'b0110; e.pc_write = zr;
      cyc(rb(), 1'b0, zr, e);
      retire_one();
    end
  endtask

  // Monitor: compare the DUT against the oldest expected vector.
  initial begin
    exp_t e, g;
    forever begin
      @(posedge clock);
      cycle++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = e;
        g.pc_write = bus.pc_write; g.ir_write = bus.ir_write;
        g.adr_src = bus.adr_src; g.mem_write = bus.mem_write;
        g.reg_write = bus.reg_write; g.src_a = bus.alu_src_a;
        g.src_b = bus.alu_src_b; g.alu_op = bus.alu_op;
        g.imm_src = bus.imm_src; g.result_src = bus.result_src;
        g.illegal = bus.illegal; g.retired = retired;
        checks++;
        if (pack(g) !== pack(e)) begin
          fails++;
          $display("FAIL %s cycle %0d: got pcw=%b irw=%b adr=%b mw=%b rw=%b a=%b b=%b op=%b imm=%b res=%b ill=%b ret=%0d, expected pcw=%b irw=%b adr=%b mw=%b rw=%b a=%b b=%b op=%b imm=%b res=%b ill=%b ret=%0d",
                   e.name, cycle,
                   g.pc_write, g.ir_write, g.adr_src, g.mem_write, g.reg_write,
                   g.src_a, g.src_b, g.alu_op, g.imm_src, g.result_src, g.illegal, g.retired,
                   e.pc_write, e.ir_write, e.adr_src, e.mem_write, e.reg_write,
                   e.src_a, e.src_b, e.alu_op, e.imm_src, e.result_src, e.illegal, e.retired);
        end
      end
    end
  end

  // Stimulus
  initial begin
    exp_t e;
    logic [31:0] ins;
    logic [6:0]  bad_ops [8];
    int          kind;
`ifdef MC_SHIFT_EN
    shift_en = 1'b1;
`else
    shift_en = 1'b0;
`endif
    bad_ops = '{7'h7F, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h73, 7'h0F, 7'h00};
    clear = 1'b1;
    bus.mem_ready = 1'b0; bus.zero = 1'b0;
    bus.opcode = '0; bus.funct3 = '0; bus.funct7b5 = 1'b0;
    cur_op = '0; cur_f3 = '0; cur_f7 = 1'b0;
    ret_model = 0;

    // second clear cycle: FETCH selects shown, writes suppressed
    e = base("clear"); e.src_b = 2'b10; e.result_src = 2'b10;
    cyc(1'b1, 1'b1, 1'b0, e);

    run_instr(32'h002081B3, 0, 0, 1'b0, 1'b0); // add
    run_instr(32'h00052183, 0, 2, 1'b0, 1'b0); // lw, 2 wait cycles
    run_instr(32'h00352423, 0, 3, 1'b0, 1'b0); // sw, 3 wait cycles
    run_instr(32'hFE0504E3, 0, 0, 1'b1, 1'b0); // beq taken
    run_instr(32'hFE0504E3, 0, 0, 1'b0, 1'b0); // beq not taken
    run_instr(32'h0000007F, 0, 0, 1'b0, 1'b0); // unsupported opcode
    run_instr(32'h00311193, 1, 0, 1'b0, 1'b0); // slli

    for (int n = 0; n < 150; n++) begin
      ins = $urandom;
      kind = $urandom_range(0, 5);
      case (kind)
        0: ins[6:0] = 7'h03;
        1: ins[6:0] = 7'h23;
        2: ins[6:0] = 7'h33;
        3: begin
             ins[6:0] = 7'h13;
             if (rb()) ins[14:12] = 3'b001;
           end
        4: ins[6:0] = 7'h63;
        default: ins[6:0] = bad_ops[$urandom_range(0, 7)];
      endcase
      run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3), rb(), 1'b0);
    end

    // clear landing in MEMWRITE: store dropped, count reset
    run_instr(32'h00352423, 0, 0, 1'b0, 1'b1);
    run_instr(32'h002081B3, 0, 0, 1'b0, 1'b0);

    @(posedge clock);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing FSM for the multicycle variant of the RV32 datapath, in which one shared memory port serves both instruction fetch and data access. It walks each instruction through fetch, decode, execute, memory and writeback states. It drives every mux select and write enable in the datapath, and stalls on a memory-ready handshake. It also keeps a retired-instruction counter for bench checking.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clock  in  1  system clock; all state changes on falling edge, matching datapath registers
- clear  in  1  synchronous, active-high reset
- opcode  in  7  instr[6:0] from instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  shared memory completed current access
- pc_write  out  1  PC register load
- ir_write  out  1  instruction/old-PC register load
- adr_src  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_write  out  1  memory write request
- reg_write  out  1  register-file write
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = reg A
- alu_src_b  out  2  00 = reg B, 01 = immediate, 10 = constant 4
- alu_op  out  4  0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt, 1000 sll
- imm_src  out  2  00 = I, 01 = S, 10 = B
- result_src  out  2  00 = ALUOut, 01 = data register, 10 = ALU result
- illegal  out  1  one-cycle flag: instruction decoded as unsupported
- retired  out  CNT_W  retired-instruction count

## Operation
- Outputs are decoded from state. Defaults are all 0, except alu_op = 0010.
- FETCH: adr_src=0, a=00, b=10, add, result_src=10. pc_write and ir_write are asserted only while mem_ready=1. Stay in FETCH while mem_ready=0. Go to DECODE when mem_ready=1.
- DECODE: a=01, b=01, add, which precomputes the branch target. imm_src follows opcode: 0x03/0x13 → 00, 0x23 → 01, 0x63 → 10.
  - 0x03 or 0x23 → MEMADR.
  - 0x33 → EXECR.
  - 0x13 → EXECI.
  - 0x63 → BEQ.
  - Any other opcode → FETCH with illegal=1.
- MEMADR: a=10, b=01, add. lw → MEMREAD; sw → MEMWRITE.
- MEMREAD: adr_src=1. Wait for mem_ready, then → MEMWB.
- MEMWB: result_src=01, reg_write=1 → FETCH.
- MEMWRITE: adr_src=1, mem_write=1, held until mem_ready. → FETCH on mem_ready.
- EXECR: a=10, b=00, alu_op from the ALU decoder.
  - funct3 000: add if funct7b5=0, sub if 1.
  - 111 → and; 110 → or; 010 → slt; 001 → sll.
  - On any other funct3: illegal=1, → FETCH, no writeback.
  - Otherwise → ALUWB.
- EXECI (slli, funct3 001 only): a=10, b=01, sll → ALUWB. Any other funct3: illegal=1, → FETCH.
- ALUWB: result_src=00, reg_write=1 → FETCH.
- BEQ: a=10, b=00, sub, result_src=00, pc_write=zero → FETCH.
- retired increments by 1 on each transition out of MEMWB, MEMWRITE, ALUWB or BEQ into FETCH. It wraps modulo 2^CNT_W. Illegal instructions do not count.

## Timing
- Reset: while clear=1, the next state is FETCH and retired is loaded with 0.
  - pc_write, ir_write, mem_write and reg_write are forced to 0 combinationally during the clear cycle.
  - illegal=0 during clear.
- Clear mid-operation, e.g. in MEMWRITE: mem_write drops in the same cycle and nothing retires.
- Cycle counts with zero-wait memory: lw 5, sw 4, R/I-type 4, beq 3 cycles.
- Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- mem_write and adr_src stay stable for the whole stall.
- illegal is high for exactly the one cycle the FSM spends in the detecting state.
- mem_ready is ignored in every state except FETCH, MEMREAD and MEMWRITE.

## Configuration
- MC_SHIFT_EN defined: R-type funct3 001 (sll) and opcode 0x13 funct3 001 (slli) decode as described above.
- MC_SHIFT_EN undefined:
  - opcode 0x13 is illegal in DECODE (→ FETCH, illegal=1, no EXECI state).
  - R-type funct3 001 is illegal in EXECR.
  - alu_op 1000 is never driven.

## Structure
- Package mc_pkg holds:
  - state enum: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ.
  - opcode constants: OP_LOAD 0x03, OP_STORE 0x23, OP_RTYPE 0x33, OP_IMM 0x13, OP_BRANCH 0x63.
  - ALU op constants and mux-select constants.
- One combinational sub-module, mc_alu_decoder, maps (funct3, funct7b5) to alu_op and a legal flag.

## Test plan
- Clear for 2 cycles, then release with mem_ready=1 → state FETCH, retired=0, pc_write=ir_write=1 in the first cycle.
- add (0x002081B3), zero-wait → FETCH, DECODE, EXECR (alu_op 0010), ALUWB (reg_write=1). retired=1 after 4 cycles.
- lw (0x00052183) with mem_ready=0 for 2 cycles in MEMREAD → 7 total cycles, reg_write=1 only in MEMWB with result_src=01.
- sw (0x00352423) with mem_ready=0 for 3 cycles → mem_write=1 and adr_src=1 for 4 consecutive cycles, then FETCH.
- beq (0xFE0504E3) with zero=1 → pc_write=1 in BEQ. With zero=0 → pc_write=0. Both retire.
- opcode 0x7F → illegal=1 for one cycle in DECODE, retired unchanged. slli (0x00311193) without MC_SHIFT_EN → illegal=1; with the macro → EXECI, alu_op 1000.
